// File: rtl/tlul_sram_responder.sv
// TL-UL device port bridged onto a req/gnt/rvalid SRAM-style interface.
// Malformed A requests are answered locally with d_error, in order with device responses.
package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [3:0]  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;

endpackage

module tlul_sram_responder
  import tlul_pkg::*;
#(
  parameter int unsigned MAX_REQS = 2,
  parameter int unsigned AW       = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  tl_h2d_t       tl_d_i,
  output tl_d2h_t       tl_d_o,
  output logic          req_o,
  input  logic          gnt_i,
  output logic          we_o,
  output logic [AW-1:0] addr_o,
  output logic [31:0]   wdata_o,
  output logic [3:0]    be_o,
  input  logic          rvalid_i,
  input  logic [31:0]   rdata_i,
  input  logic          err_i
);

  localparam int unsigned PW = (MAX_REQS > 1) ? $clog2(MAX_REQS) : 1;
  localparam int unsigned CW = $clog2(MAX_REQS + 1);
  localparam logic [PW-1:0] LastIdx = PW'(MAX_REQS - 1);
  localparam logic [CW-1:0] MaxCnt  = CW'(MAX_REQS);

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] size;
    logic [7:0] source;
    logic       local_err;
  } meta_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  meta_t          meta_mem_q [MAX_REQS];
  meta_t          meta_mem_d [MAX_REQS];
  resp_t          resp_mem_q [MAX_REQS];
  resp_t          resp_mem_d [MAX_REQS];
  logic [PW-1:0]  meta_wptr_q, meta_wptr_d, meta_rptr_q, meta_rptr_d;
  logic [PW-1:0]  resp_wptr_q, resp_wptr_d, resp_rptr_q, resp_rptr_d;
  logic [CW-1:0]  meta_cnt_q, meta_cnt_d, resp_cnt_q, resp_cnt_d;
  logic [CW-1:0]  dev_pend_q, dev_pend_d;

  logic       malformed, meta_space, a_ready, accept, grant, rsp_push;
  logic       d_valid, d_error, d_hs, resp_pop;
  logic [3:0] full_mask;
  meta_t      meta_head;
  resp_t      resp_head;
  logic       unused_param;

  assign unused_param = ^tl_d_i.a_param;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LastIdx) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    malformed = 1'b0;
    unique case (tl_d_i.a_size)
      2'd0:    full_mask = 4'b0001 << tl_d_i.a_address[1:0];
      2'd1:    full_mask = 4'b0011 << tl_d_i.a_address[1:0];
      2'd2:    full_mask = 4'b1111;
      default: full_mask = 4'b0000;
    endcase
    if (!(tl_d_i.a_opcode inside {Get, PutFullData, PutPartialData})) malformed = 1'b1;
    if (tl_d_i.a_size == 2'd3) malformed = 1'b1;
    if (tl_d_i.a_size == 2'd1 && tl_d_i.a_address[0]) malformed = 1'b1;
    if (tl_d_i.a_size == 2'd2 && tl_d_i.a_address[1:0] != 2'b00) malformed = 1'b1;
    if (tl_d_i.a_opcode == PutFullData && tl_d_i.a_mask != full_mask) malformed = 1'b1;
  end

  // Room is judged on the pre-pop count so a same-cycle D pop never frees a slot early.
  assign meta_space = meta_cnt_q < MaxCnt;
  assign req_o      = !reset & tl_d_i.a_valid & !malformed & meta_space;
  assign grant      = req_o & gnt_i;
  assign a_ready    = !reset & (grant | (tl_d_i.a_valid & malformed & meta_space));
  assign accept     = tl_d_i.a_valid & a_ready;
  assign rsp_push   = rvalid_i & (dev_pend_q != '0);

  assign we_o    = tl_d_i.a_opcode != Get;
  assign addr_o  = AW'(tl_d_i.a_address);
  assign wdata_o = tl_d_i.a_data;
  assign be_o    = tl_d_i.a_mask;

  assign meta_head = meta_mem_q[meta_rptr_q];
  assign resp_head = resp_mem_q[resp_rptr_q];
  assign d_valid   = (meta_cnt_q != '0) & (meta_head.local_err | (resp_cnt_q != '0));
  assign d_error   = meta_head.local_err | resp_head.err;
  assign d_hs      = d_valid & tl_d_i.d_ready;
  assign resp_pop  = d_hs & !meta_head.local_err;

  always_comb begin
    tl_d_o          = '0;
    tl_d_o.a_ready  = a_ready;
    tl_d_o.d_valid  = d_valid;
    tl_d_o.d_opcode = (meta_head.opcode == Get) ? AccessAckData : AccessAck;
    tl_d_o.d_size   = meta_head.size;
    tl_d_o.d_source = meta_head.source;
    tl_d_o.d_error  = d_error;
    if (meta_head.opcode == Get && !d_error) tl_d_o.d_data = resp_head.rdata;
  end

  always_comb begin
    meta_mem_d  = meta_mem_q;
    meta_wptr_d = meta_wptr_q;
    meta_rptr_d = meta_rptr_q;
    resp_mem_d  = resp_mem_q;
    resp_wptr_d = resp_wptr_q;
    resp_rptr_d = resp_rptr_q;
    if (accept) begin
      meta_mem_d[meta_wptr_q] = '{opcode:    tl_d_i.a_opcode,
                                  size:      tl_d_i.a_size,
                                  source:    tl_d_i.a_source,
                                  local_err: malformed};
      meta_wptr_d = bump(meta_wptr_q);
    end
    if (d_hs) meta_rptr_d = bump(meta_rptr_q);
    if (rsp_push) begin
      resp_mem_d[resp_wptr_q] = '{rdata: rdata_i, err: err_i};
      resp_wptr_d = bump(resp_wptr_q);
    end
    if (resp_pop) resp_rptr_d = bump(resp_rptr_q);
    meta_cnt_d = meta_cnt_q + CW'(accept) - CW'(d_hs);
    resp_cnt_d = resp_cnt_q + CW'(rsp_push) - CW'(resp_pop);
    dev_pend_d = dev_pend_q + CW'(grant) - CW'(rsp_push);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_wptr_q <= '0;
      meta_rptr_q <= '0;
      meta_cnt_q  <= '0;
      resp_wptr_q <= '0;
      resp_rptr_q <= '0;
      resp_cnt_q  <= '0;
      dev_pend_q  <= '0;
    end else begin
      meta_wptr_q <= meta_wptr_d;
      meta_rptr_q <= meta_rptr_d;
      meta_cnt_q  <= meta_cnt_d;
      resp_wptr_q <= resp_wptr_d;
      resp_rptr_q <= resp_rptr_d;
      resp_cnt_q  <= resp_cnt_d;
      dev_pend_q  <= dev_pend_d;
    end
  end

  // Storage needs no reset: entries are only observed through the counts.
  always_ff @(posedge clock) begin
    meta_mem_q <= meta_mem_d;
    resp_mem_q <= resp_mem_d;
  end

  rvalid_has_req_a: assert property (@(posedge clock) disable iff (reset)
    rvalid_i |-> (dev_pend_q != '0));

endmodule

// File: tb/tb_tlul_sram_responder.sv
// Randomized and directed bench for tlul_sram_responder, checked every cycle against
// a queue-based model of in-order TL-UL responses plus a simple memory device.
module tb_tlul_sram_responder;
  import tlul_pkg::*;

  localparam int MaxReqs = 2;
  localparam int Inf     = 32'h7fffffff;

  logic        clock = 1'b0;
  logic        reset;
  tl_h2d_t     tl_i;
  tl_d2h_t     tl_o;
  logic        req_o, gnt_i, we_o, rvalid_i, err_i;
  logic [31:0] addr_o, wdata_o, rdata_i;
  logic [3:0]  be_o;

  tlul_sram_responder #(.MAX_REQS(MaxReqs), .AW(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .tl_d_i   (tl_i),
    .tl_d_o   (tl_o),
    .req_o    (req_o),
    .gnt_i    (gnt_i),
    .we_o     (we_o),
    .addr_o   (addr_o),
    .wdata_o  (wdata_o),
    .be_o     (be_o),
    .rvalid_i (rvalid_i),
    .rdata_i  (rdata_i),
    .err_i    (err_i)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } areq_t;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic [31:0] data;
    logic        err;
    logic        local_err;
    int          avail;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } dev_t;

  typedef struct {
    int          cyc;
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic [31:0] data;
    logic        err;
  } beat_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_due = 0;
  bit started = 0;
  bit a_taken = 0;
  bit rv_now  = 0;

  int gnt_pct = 100, dready_pct = 100, err_pct = 0, a_pct = 100, lat_min = 1, lat_max = 1;

  areq_t       a_pend[$];
  exp_t        exp_q[$];
  dev_t        dev_q[$];
  logic [31:0] mem [256];

  beat_t       beats[$];
  int          rv_cyc[$], g_cyc[$], acc_cyc[$];
  logic        g_we[$];
  logic [3:0]  g_be[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic is_bad(input logic [2:0] op, input logic [1:0] sz,
                                  input logic [31:0] a, input logic [3:0] m);
    int nbytes;
    logic [3:0] want;
    if (op != 3'd0 && op != 3'd1 && op != 3'd4) return 1'b1;
    if (sz > 2'd2) return 1'b1;
    nbytes = 1 << sz;
    if ((a % nbytes) != 0) return 1'b1;
    want = 4'((1 << nbytes) - 1) << a[1:0];
    if (op == 3'd0 && m != want) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_req(input logic [2:0] op, input logic [1:0] sz, input logic [7:0] src,
                          input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] data);
    areq_t r;
    r.op = op; r.size = sz; r.src = src; r.addr = addr; r.mask = mask; r.data = data;
    a_pend.push_back(r);
  endtask

  task automatic push_rand_req();
    int k, nb;
    logic [2:0] op;
    logic [1:0] sz;
    logic [31:0] addr;
    logic [3:0] mask;
    k  = $urandom_range(99);
    op = (k < 40) ? 3'd4 : (k < 65) ? 3'd0 : (k < 92) ? 3'd1 : 3'($urandom);
    sz = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
    nb = 1 << sz;
    addr = {22'h0, 8'($urandom), 2'b00};
    if ($urandom_range(9) == 0) addr[1:0] = 2'($urandom);
    else if (sz < 2'd3) addr[1:0] = 2'(($urandom_range(3) / nb) * nb);
    mask = 4'($urandom);
    if (op == 3'd0 && $urandom_range(9) != 0) mask = 4'((1 << nb) - 1) << addr[1:0];
    push_req(op, sz, 8'($urandom), addr, mask, $urandom);
  endtask

  task automatic clear_logs();
    beats.delete(); rv_cyc.delete(); g_cyc.delete(); acc_cyc.delete();
    g_we.delete(); g_be.delete();
  endtask

  task automatic tick();
    areq_t r;
    logic mal, room, exp_req, exp_ardy, exp_dv;
    @(posedge clock);
    #1;
    rv_now = 1'b0;
    if (dev_q.size() > 0 && dev_q[0].due <= cyc) begin
      rvalid_i = 1'b1; rdata_i = dev_q[0].rdata; err_i = dev_q[0].err; rv_now = 1'b1;
    end else begin
      rvalid_i = 1'b0; rdata_i = $urandom; err_i = 1'($urandom);
    end
    gnt_i        = ($urandom_range(99) < gnt_pct);
    tl_i.d_ready = ($urandom_range(99) < dready_pct);
    if (!tl_i.a_valid || a_taken) begin
      a_taken = 1'b0;
      if (a_pend.size() > 0 && $urandom_range(99) < a_pct) begin
        r = a_pend.pop_front();
        tl_i.a_valid = 1'b1; tl_i.a_opcode = r.op; tl_i.a_size = r.size;
        tl_i.a_source = r.src; tl_i.a_address = r.addr; tl_i.a_mask = r.mask;
        tl_i.a_data = r.data; tl_i.a_param = 3'd0;
      end else begin
        tl_i.a_valid = 1'b0; tl_i.a_opcode = 3'($urandom); tl_i.a_address = $urandom;
      end
    end

    @(negedge clock);
    mal      = is_bad(tl_i.a_opcode, tl_i.a_size, tl_i.a_address, tl_i.a_mask);
    room     = exp_q.size() < MaxReqs;
    exp_req  = !reset && tl_i.a_valid && !mal && room;
    exp_ardy = !reset && ((exp_req && gnt_i) || (tl_i.a_valid && mal && room));
    chk("req_o", req_o, exp_req);
    chk("a_ready", tl_o.a_ready, exp_ardy);
    if (exp_req) begin
      chk("we_o", we_o, tl_i.a_opcode != 3'd4);
      chk("addr_o", addr_o, tl_i.a_address);
      chk("wdata_o", wdata_o, tl_i.a_data);
      chk("be_o", be_o, tl_i.a_mask);
    end
    exp_dv = exp_q.size() > 0 && exp_q[0].avail <= cyc;
    if (started) begin
      chk("d_valid", tl_o.d_valid, exp_dv);
      if (exp_dv) begin
        chk("d_opcode", tl_o.d_opcode, (exp_q[0].op == 3'd4) ? 3'd1 : 3'd0);
        chk("d_size", tl_o.d_size, exp_q[0].size);
        chk("d_source", tl_o.d_source, exp_q[0].src);
        chk("d_data", tl_o.d_data, exp_q[0].data);
        chk("d_error", tl_o.d_error, exp_q[0].err);
        chk("d_param_sink_user", {tl_o.d_param, tl_o.d_sink, tl_o.d_user}, 0);
      end
    end

    if (reset) begin
      started = 1'b1;
      exp_q.delete(); dev_q.delete();
      last_due = cyc;
      if (tl_i.a_valid) a_taken = 1'b1;
    end else begin
      if (tl_o.d_valid && tl_i.d_ready) begin
        beats.push_back('{cyc: cyc, op: tl_o.d_opcode, size: tl_o.d_size, src: tl_o.d_source,
                          data: tl_o.d_data, err: tl_o.d_error});
        if (exp_dv) void'(exp_q.pop_front());
      end
      if (rv_now) begin
        void'(dev_q.pop_front());
        rv_cyc.push_back(cyc);
        for (int i = 0; i < exp_q.size(); i++) begin
          if (!exp_q[i].local_err && exp_q[i].avail == Inf) begin
            exp_q[i].avail = cyc + 1;
            break;
          end
        end
      end
      if (tl_i.a_valid && exp_ardy) begin
        exp_t e;
        a_taken = 1'b1;
        acc_cyc.push_back(cyc);
        e.op = tl_i.a_opcode; e.size = tl_i.a_size; e.src = tl_i.a_source;
        if (mal) begin
          e.data = 0; e.err = 1'b1; e.local_err = 1'b1; e.avail = cyc + 1;
        end else begin
          dev_t d;
          logic [7:0] idx;
          idx   = tl_i.a_address[9:2];
          d.due = cyc + $urandom_range(lat_max, lat_min);
          if (d.due <= last_due) d.due = last_due + 1;
          last_due = d.due;
          d.err = ($urandom_range(99) < err_pct);
          if (tl_i.a_opcode == 3'd4) d.rdata = mem[idx];
          else begin
            d.rdata = $urandom;
            for (int b = 0; b < 4; b++)
              if (tl_i.a_mask[b]) mem[idx][8*b +: 8] = tl_i.a_data[8*b +: 8];
          end
          dev_q.push_back(d);
          g_cyc.push_back(cyc); g_we.push_back(we_o); g_be.push_back(be_o);
          e.data = (tl_i.a_opcode == 3'd4 && !d.err) ? d.rdata : 32'h0;
          e.err = d.err; e.local_err = 1'b0; e.avail = Inf;
        end
        exp_q.push_back(e);
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    tl_i = '0; gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; err_i = 1'b0;
    reset = 1'b1;
    run(3);
    reset = 1'b0;

    // Single Get, grant same cycle, response two cycles later.
    clear_logs();
    mem[8'h40] = 32'hDEADBEEF;
    lat_min = 2; lat_max = 2;
    push_req(3'd4, 2'd2, 8'd3, 32'h100, 4'hF, 32'h0);
    run(8);
    chk("t1_beats", beats.size(), 1);
    if (beats.size() == 1 && rv_cyc.size() == 1 && g_cyc.size() == 1) begin
      chk("t1_opcode", beats[0].op, 3'd1);
      chk("t1_source", beats[0].src, 8'd3);
      chk("t1_size", beats[0].size, 2'd2);
      chk("t1_data", beats[0].data, 32'hDEADBEEF);
      chk("t1_error", beats[0].err, 1'b0);
      chk("t1_rv_lat", rv_cyc[0] - g_cyc[0], 2);
      chk("t1_d_lat", beats[0].cyc - rv_cyc[0], 1);
    end

    // PutPartialData answered with a device error.
    clear_logs();
    lat_min = 1; lat_max = 1; err_pct = 100;
    push_req(3'd1, 2'd2, 8'd4, 32'h104, 4'h6, 32'hA5A5A5A5);
    run(6);
    err_pct = 0;
    chk("t2_grants", g_cyc.size(), 1);
    chk("t2_beats", beats.size(), 1);
    if (g_cyc.size() == 1 && beats.size() == 1) begin
      chk("t2_we", g_we[0], 1'b1);
      chk("t2_be", g_be[0], 4'h6);
      chk("t2_opcode", beats[0].op, 3'd0);
      chk("t2_error", beats[0].err, 1'b1);
      chk("t2_data", beats[0].data, 32'h0);
    end

    // Misaligned Get answered locally, then a good Get in order.
    clear_logs();
    mem[8'h42] = 32'h12345678;
    push_req(3'd4, 2'd2, 8'd5, 32'h102, 4'hF, 32'h0);
    push_req(3'd4, 2'd2, 8'd6, 32'h108, 4'hF, 32'h0);
    run(8);
    chk("t3_grants", g_cyc.size(), 1);
    chk("t3_beats", beats.size(), 2);
    if (beats.size() == 2) begin
      chk("t3_src0", beats[0].src, 8'd5);
      chk("t3_err0", beats[0].err, 1'b1);
      chk("t3_data0", beats[0].data, 32'h0);
      chk("t3_src1", beats[1].src, 8'd6);
      chk("t3_err1", beats[1].err, 1'b0);
      chk("t3_data1", beats[1].data, 32'h12345678);
    end

    // Three Gets with d_ready low: the third waits for the first handshake.
    clear_logs();
    dready_pct = 0;
    push_req(3'd4, 2'd2, 8'd7, 32'h10, 4'hF, 32'h0);
    push_req(3'd4, 2'd2, 8'd8, 32'h14, 4'hF, 32'h0);
    push_req(3'd4, 2'd2, 8'd9, 32'h18, 4'hF, 32'h0);
    run(10);
    chk("t4_stalled_beats", beats.size(), 0);
    chk("t4_stalled_accepts", acc_cyc.size(), 2);
    dready_pct = 100;
    run(10);
    chk("t4_beats", beats.size(), 3);
    if (beats.size() == 3 && acc_cyc.size() == 3) begin
      chk("t4_src0", beats[0].src, 8'd7);
      chk("t4_src1", beats[1].src, 8'd8);
      chk("t4_src2", beats[2].src, 8'd9);
      chk("t4_third_after_pop", acc_cyc[2] > beats[0].cyc, 1'b1);
    end

    // Reset with two requests outstanding, then a fresh Get.
    clear_logs();
    dready_pct = 0; lat_min = 8; lat_max = 8;
    push_req(3'd4, 2'd2, 8'd1, 32'h20, 4'hF, 32'h0);
    push_req(3'd4, 2'd2, 8'd2, 32'h24, 4'hF, 32'h0);
    run(3);
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    run(1);
    chk("t5_dvalid_after_reset", tl_o.d_valid, 1'b0);
    clear_logs();
    dready_pct = 100; lat_min = 1; lat_max = 1;
    push_req(3'd4, 2'd2, 8'hA, 32'h30, 4'hF, 32'h0);
    run(8);
    chk("t5_beats", beats.size(), 1);
    if (beats.size() == 1) chk("t5_src", beats[0].src, 8'hA);

    // Random traffic including malformed requests, device stalls and back-pressure.
    gnt_pct = 60; dready_pct = 60; err_pct = 15; a_pct = 70; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      if (a_pend.size() == 0) push_rand_req();
      tick();
    end
    a_pend.delete();
    gnt_pct = 100; dready_pct = 100;
    for (int i = 0; i < 200 && (exp_q.size() > 0 || (tl_i.a_valid && !a_taken)); i++) tick();
    chk("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlul_sram_responder.md
TLUL_SRAM_RESPONDER -- requirements
Module: tlul_sram_responder

Interface
REQ-001 SHALL have parameter MAX_REQS, default 2, meaning the maximum number of accepted-but-unanswered A-channel requests (range 1..8).
REQ-002 SHALL have parameter AW, default 32, meaning the width of the device address output.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, the reset: synchronous, active-high.
REQ-005 SHALL have port tl_d_i, input, tlul_pkg::tl_h2d_t, TL-UL A channel from the host, plus d_ready.
REQ-006 SHALL have port tl_d_o, output, tlul_pkg::tl_d2h_t, TL-UL D channel to the host, plus a_ready.
REQ-007 SHALL have port req_o, output, 1, device request valid.
REQ-008 SHALL have port gnt_i, input, 1, device accepts the request this cycle.
REQ-009 SHALL have port we_o, output, 1, 1 = write.
REQ-010 SHALL have port addr_o, output, AW, byte address (a_address).
REQ-011 SHALL have port wdata_o, output, 32, write data (a_data).
REQ-012 SHALL have port be_o, output, 4, byte enables (a_mask).
REQ-013 SHALL have port rvalid_i, input, 1, device response valid, one per granted request, in order.
REQ-014 SHALL have port rdata_i, input, 32, read data, qualified by rvalid_i.
REQ-015 SHALL have port err_i, input, 1, device error, qualified by rvalid_i.

Function
REQ-016 Malformed A request SHALL be one of: opcode not Get(4)/PutFullData(0)/PutPartialData(1); a_size > 2; address not aligned to 2^a_size; PutFullData with a_mask not covering exactly the sized bytes.
REQ-017 Meta FIFO (depth MAX_REQS) SHALL store {opcode, size, source, local_err} per accepted request; response FIFO (depth MAX_REQS) SHALL store {rdata, err} per rvalid_i.
REQ-018 req_o SHALL equal a_valid & !malformed & (meta count < MAX_REQS); we_o = (opcode != Get).
REQ-019 a_ready SHALL equal (req_o & gnt_i) | (a_valid & malformed & meta count < MAX_REQS); acceptance = a_valid & a_ready.
REQ-020 On acceptance, the block SHALL push a meta entry, with local_err = malformed; malformed requests never reach the device.
REQ-021 On rvalid_i, the block SHALL push {rdata_i, err_i} into the response FIFO in the same edge.
REQ-022 d_valid SHALL equal meta non-empty & (head.local_err | response FIFO non-empty).
REQ-023 D fields SHALL be: d_opcode = AccessAckData(1) for Get else AccessAck(0); d_size/d_source echo the head; d_param = 0; d_sink = 0; d_user = 0.
REQ-024 d_data SHALL be the response rdata for Get without error, else 0; d_error = head.local_err | response err.
REQ-025 On a D handshake (d_valid & d_ready), the block SHALL pop meta, and pop the response FIFO iff head.local_err = 0.
REQ-026 Responses SHALL return in acceptance order, with local-error responses ordered among device responses.
REQ-027 Latency: rvalid_i in cycle N SHALL give d_valid in N+1; malformed acceptance in N SHALL give d_valid in N+1 if it is at the head.
REQ-028 Simultaneous push and pop on either FIFO SHALL keep the count unchanged; at full, a pop in the same cycle SHALL NOT enable acceptance (count check uses pre-pop value).
REQ-029 d_valid with d_ready = 0 SHALL hold all D fields stable until the handshake.
REQ-030 rvalid_i with no outstanding device request is a protocol violation and SHALL be flagged by an assertion; the data is dropped.

Reset
REQ-031 With reset high at a clock edge, both FIFOs SHALL empty; in the following cycle d_valid = 0.
REQ-032 While reset is high, req_o and a_ready SHALL be 0.
REQ-033 Reset mid-transaction SHALL discard pending responses; no D beat for pre-reset requests.

Verification
REQ-034 Get addr 0x100, size 2, source 3, gnt same cycle; rvalid 2 cycles later with rdata 0xDEADBEEF -> one D beat: opcode 1, source 3, size 2, data 0xDEADBEEF, error 0, cycle after rvalid.
REQ-035 PutPartialData mask 0x6 -> we_o 1, be_o 0x6; err_i 1 on response -> AccessAck with d_error 1, d_data 0.
REQ-036 Get size 2 at 0x102 followed by a valid Get -> first D has error 1 with no device request issued; second D follows in order.
REQ-037 MAX_REQS = 2, three back-to-back Gets, d_ready held 0 -> third a_ready stays 0 until the first D handshake; no response is lost or reordered.
REQ-038 Reset asserted with 2 outstanding requests -> d_valid 0 after reset; a new Get completes normally.
